// File: rtl/lsu_seq_pkg.sv
// ============================================================================
// Module   : lsu_seq_pkg
// Purpose  : Shared definitions for the load/store unit.
//            - funct3 size encodings (LSU_SIZE_B/H/W)
//            - lsu_state_t sequencer state encoding
//            - lsu_misaligned(): alignment check for a size/byte-offset pair
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_seq_pkg;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } lsu_state_t;

  // Bytes never cross a word; halves must be even; words (and the unused
  // size 11, treated as word) must be word aligned.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] off);
    logic mis;
    case (size)
      LSU_SIZE_B: mis = 1'b0;
      LSU_SIZE_H: mis = off[0];
      default:    mis = (off != 2'b00);
    endcase
    return mis;
  endfunction

endpackage : lsu_seq_pkg

`default_nettype wire

// File: rtl/lsu_seq_if.sv
// ============================================================================
// Module   : lsu_seq_if
// Purpose  : Signal bundle between the core / data-memory bus and lsu_seq.
//            Signal names carry the LSU's point of view (i_ = into LSU).
// Modports : slave  - the LSU itself
//            master - the environment (core execute stage + memory bus)
// Signals  : i_valid, i_store, i_funct3[2:0], i_addr[31:0], i_wdata[31:0]
//            o_stall, o_rd_valid, o_rd_wdata[31:0], o_misaligned, o_bus_err
//            o_mem_req, o_mem_we, o_mem_addr[31:0], o_mem_wdata[31:0],
//            o_mem_wmask[3:0], i_mem_ack, i_mem_rdata[31:0]
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lsu_seq_if;

  // Core side
  logic        i_valid;
  logic        i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_stall;
  logic        o_rd_valid;
  logic [31:0] o_rd_wdata;
  logic        o_misaligned;
  logic        o_bus_err;

  // Memory side
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;

  modport slave (
    input  i_valid, i_store, i_funct3, i_addr, i_wdata,
    output o_stall, o_rd_valid, o_rd_wdata, o_misaligned, o_bus_err,
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    input  i_mem_ack, i_mem_rdata
  );

  modport master (
    output i_valid, i_store, i_funct3, i_addr, i_wdata,
    input  o_stall, o_rd_valid, o_rd_wdata, o_misaligned, o_bus_err,
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask,
    output i_mem_ack, i_mem_rdata
  );

endinterface : lsu_seq_if

`default_nettype wire

// File: rtl/lsu_seq_align.sv
// ============================================================================
// Module   : lsu_seq_align
// Purpose  : Combinational data steering for the load/store unit.
//            Store side: replicate store data into byte lanes and build mask.
//            Load side : extract the addressed byte/half/word and extend it.
// Ports    : st_size_i[1:0], st_off_i[1:0], st_data_i[31:0]  store request
//            st_lanes_o[31:0], st_mask_o[3:0]                 bus write data
//            ld_size_i[1:0], ld_unsigned_i, ld_off_i[1:0]     load request
//            ld_rdata_i[31:0]                                 bus read word
//            ld_data_o[31:0]                                  extended result
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_seq_align
  import lsu_seq_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_data_i,
  output logic [31:0] st_lanes_o,
  output logic [3:0]  st_mask_o,
  input  logic [1:0]  ld_size_i,
  input  logic        ld_unsigned_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] ld_shifted;

  always_comb begin
    st_lanes_o = st_data_i;
    st_mask_o  = 4'b1111;
    case (st_size_i)
      LSU_SIZE_B: begin
        st_lanes_o = {4{st_data_i[7:0]}};
        st_mask_o  = 4'b0001 << st_off_i;
      end
      LSU_SIZE_H: begin
        st_lanes_o = {2{st_data_i[15:0]}};
        st_mask_o  = 4'b0011 << {st_off_i[1], 1'b0};
      end
      default: begin
        st_lanes_o = st_data_i;
        st_mask_o  = 4'b1111;
      end
    endcase
  end

  // Bring the addressed byte lane down to bit 0 before extension.
  assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

  always_comb begin
    ld_data_o = ld_shifted;
    case (ld_size_i)
      LSU_SIZE_B: ld_data_o = ld_unsigned_i ? {24'h000000, ld_shifted[7:0]}
                                            : {{24{ld_shifted[7]}}, ld_shifted[7:0]};
      LSU_SIZE_H: ld_data_o = ld_unsigned_i ? {16'h0000, ld_shifted[15:0]}
                                            : {{16{ld_shifted[15]}}, ld_shifted[15:0]};
      default:    ld_data_o = ld_shifted;
    endcase
  end

endmodule : lsu_seq_align

`default_nettype wire

// File: rtl/lsu_seq.sv
// ============================================================================
// Module   : lsu_seq
// Purpose  : Multi-cycle load/store unit between execute stage and a
//            word-aligned req/ack data bus. Stalls the core while an access
//            is outstanding and returns the extended load result.
//            Optional ack timeout enabled with macro LSU_TIMEOUT_EN.
// Params   : TIMEOUT_CYCLES - REQ cycles without ack before bus error
//                             (1..65535, used only with LSU_TIMEOUT_EN)
// Ports    : i_clk  - clock, rising edge
//            i_rst  - asynchronous active-high reset
//            bus    - lsu_seq_if.slave (core request/result + memory bus)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_seq
  import lsu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic     i_clk,
  input  logic     i_rst,
  lsu_seq_if.slave bus
);

  lsu_state_t  state_q,  state_d;
  logic [31:0] addr_q,   addr_d;
  logic [1:0]  off_q,    off_d;
  logic        we_q,     we_d;
  logic [31:0] wdata_q,  wdata_d;
  logic [3:0]  mask_q,   mask_d;
  logic [1:0]  size_q,   size_d;
  logic        uns_q,    uns_d;
  logic        mis_q,    mis_d;
  logic [31:0] result_q, result_d;
  logic        stall;
  logic        req_misaligned;

  logic [31:0] st_lanes;
  logic [3:0]  st_mask;
  logic [31:0] ld_data;

`ifdef LSU_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q,     err_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES == 0);
`endif

  lsu_seq_align u_align (
    .st_size_i     (bus.i_funct3[1:0]),
    .st_off_i      (bus.i_addr[1:0]),
    .st_data_i     (bus.i_wdata),
    .st_lanes_o    (st_lanes),
    .st_mask_o     (st_mask),
    .ld_size_i     (size_q),
    .ld_unsigned_i (uns_q),
    .ld_off_i      (off_q),
    .ld_rdata_i    (bus.i_mem_rdata),
    .ld_data_o     (ld_data)
  );

  assign req_misaligned = lsu_misaligned(bus.i_funct3[1:0], bus.i_addr[1:0]);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      mask_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      mis_q     <= 1'b0;
      result_q  <= '0;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      mask_q    <= mask_d;
      size_q    <= size_d;
      uns_q     <= uns_d;
      mis_q     <= mis_d;
      result_q  <= result_d;
`ifdef LSU_TIMEOUT_EN
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    off_d     = off_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    mask_d    = mask_q;
    size_d    = size_q;
    uns_d     = uns_q;
    mis_d     = mis_q;
    result_d  = result_q;
    stall     = 1'b0;
`ifdef LSU_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          stall = 1'b1;
          mis_d = req_misaligned;
`ifdef LSU_TIMEOUT_EN
          tmo_cnt_d = '0;
          err_d     = 1'b0;
`endif
          if (req_misaligned) begin
            // No bus cycle; the fault is reported as the instruction retires.
            state_d = RESP;
          end else begin
            addr_d  = {bus.i_addr[31:2], 2'b00};
            off_d   = bus.i_addr[1:0];
            we_d    = bus.i_store;
            wdata_d = st_lanes;
            mask_d  = bus.i_store ? st_mask : 4'b0000;
            size_d  = bus.i_funct3[1:0];
            uns_d   = bus.i_funct3[2];
            state_d = REQ;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (bus.i_mem_ack) begin
          if (!we_q) result_d = ld_data;
          state_d = RESP;
        end
`ifdef LSU_TIMEOUT_EN
        // An ack in the limit cycle takes the branch above and completes.
        else if (tmo_cnt_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
`endif
      end
      RESP: begin
        // i_valid here belongs to the retiring instruction and is ignored.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.o_stall      = stall;
  assign bus.o_mem_req    = (state_q == REQ);
  assign bus.o_mem_we     = we_q && (state_q == REQ);
  assign bus.o_mem_addr   = addr_q;
  assign bus.o_mem_wdata  = wdata_q;
  assign bus.o_mem_wmask  = mask_q;
  assign bus.o_rd_wdata   = result_q;
  assign bus.o_misaligned = (state_q == RESP) && mis_q;
`ifdef LSU_TIMEOUT_EN
  assign bus.o_rd_valid   = (state_q == RESP) && !we_q && !mis_q && !err_q;
  assign bus.o_bus_err    = (state_q == RESP) && err_q;
`else
  assign bus.o_rd_valid   = (state_q == RESP) && !we_q && !mis_q;
  assign bus.o_bus_err    = 1'b0;
`endif

endmodule : lsu_seq

`default_nettype wire

// File: tb/tb_lsu_seq.sv
// ============================================================================
// Module   : tb_lsu_seq
// Purpose  : Directed self-checking bench for lsu_seq (timeout scenario is
//            exercised when LSU_TIMEOUT_EN is defined).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lsu_seq;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Per-access observations
  int          r_stall, r_req, r_rdv, r_mis, r_err;
  logic        r_stable, r_hung, r_post, r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_mask;

  lsu_seq_if bus ();

  lsu_seq #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one access; ack on REQ cycle number ack_dly (0 = first), or never
  // when ack_dly < 0. Returns after the cycle following retirement.
  task automatic access(input logic st, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int ack_dly);
    bus.i_valid = 1'b1; bus.i_store = st; bus.i_funct3 = f3; bus.i_addr = a;
    bus.i_wdata = wd; bus.i_mem_rdata = rd; bus.i_mem_ack = 1'b0;
    r_stall = 0; r_req = 0; r_rdv = 0; r_mis = 0; r_err = 0;
    r_stable = 1'b1; r_hung = 1'b1; r_we = 1'b0;
    r_addr = '0; r_wdata = '0; r_mask = '0; r_rdata = '0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      #1;
      if (bus.o_stall) r_stall++;
      if (bus.o_mem_req) begin
        if (r_req == 0) begin
          r_addr = bus.o_mem_addr; r_wdata = bus.o_mem_wdata;
          r_mask = bus.o_mem_wmask; r_we = bus.o_mem_we;
        end else if (bus.o_mem_addr !== r_addr) begin
          r_stable = 1'b0;
        end
        bus.i_mem_ack = (r_req == ack_dly);
        r_req++;
      end else begin
        bus.i_mem_ack = 1'b0;
      end
      if (bus.o_rd_valid) begin r_rdv++; r_rdata = bus.o_rd_wdata; end
      if (bus.o_misaligned) r_mis++;
      if (bus.o_bus_err) r_err++;
      if (!bus.o_stall) begin r_hung = 1'b0; break; end
      @(posedge clk);
    end
    bus.i_valid = 1'b0; bus.i_mem_ack = 1'b0;
    @(posedge clk); #1;
    r_post = bus.o_rd_valid | bus.o_misaligned | bus.o_bus_err | bus.o_mem_req;
    chk("hung", {31'd0, r_hung}, 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1;
    bus.i_valid = 1'b0; bus.i_store = 1'b0; bus.i_funct3 = 3'b000;
    bus.i_addr = '0; bus.i_wdata = '0; bus.i_mem_ack = 1'b0; bus.i_mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req",    {31'd0, bus.o_mem_req},    32'd0);
    chk("rst_we",     {31'd0, bus.o_mem_we},     32'd0);
    chk("rst_rdv",    {31'd0, bus.o_rd_valid},   32'd0);
    chk("rst_mis",    {31'd0, bus.o_misaligned}, 32'd0);
    chk("rst_err",    {31'd0, bus.o_bus_err},    32'd0);
    chk("rst_stall",  {31'd0, bus.o_stall},      32'd0);
    chk("rst_addr",   bus.o_mem_addr,            32'd0);
    chk("rst_wdata",  bus.o_mem_wdata,           32'd0);
    chk("rst_rdata",  bus.o_rd_wdata,            32'd0);
    chk("rst_mask",   {28'd0, bus.o_mem_wmask},  32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // SW 0x100, ack in first REQ cycle
    access(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0);
    chk("sw_addr",  r_addr,             32'h0000_0100);
    chk("sw_wdata", r_wdata,            32'hDEAD_BEEF);
    chk("sw_mask",  {28'd0, r_mask},    32'h0000_000F);
    chk("sw_we",    {31'd0, r_we},      32'd1);
    chk("sw_stall", r_stall,            32'd2);
    chk("sw_rdv",   r_rdv,              32'd0);
    chk("sw_post",  {31'd0, r_post},    32'd0);

    // SB 0x103
    access(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h0, 0);
    chk("sb_addr",  r_addr,             32'h0000_0100);
    chk("sb_wdata", r_wdata,            32'hA5A5_A5A5);
    chk("sb_mask",  {28'd0, r_mask},    32'h0000_0008);
    chk("sb_rdv",   r_rdv,              32'd0);

    // SH 0x102
    access(1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 1);
    chk("sh_wdata", r_wdata,            32'h1234_1234);
    chk("sh_mask",  {28'd0, r_mask},    32'h0000_000C);
    chk("sh_stall", r_stall,            32'd3);

    // LB / LBU 0x202
    access(1'b0, 3'b000, 32'h0000_0202, 32'h0, 32'h0080_0000, 0);
    chk("lb_addr",  r_addr,             32'h0000_0200);
    chk("lb_mask",  {28'd0, r_mask},    32'h0000_0000);
    chk("lb_we",    {31'd0, r_we},      32'd0);
    chk("lb_rdv",   r_rdv,              32'd1);
    chk("lb_data",  r_rdata,            32'hFFFF_FF80);
    chk("lb_stall", r_stall,            32'd2);
    chk("lb_post",  {31'd0, r_post},    32'd0);
    access(1'b0, 3'b100, 32'h0000_0202, 32'h0, 32'h0080_0000, 0);
    chk("lbu_data", r_rdata,            32'h0000_0080);

    // LH / LHU 0x102
    access(1'b0, 3'b001, 32'h0000_0102, 32'h0, 32'h8001_0000, 0);
    chk("lh_data",  r_rdata,            32'hFFFF_8001);
    access(1'b0, 3'b101, 32'h0000_0102, 32'h0, 32'h8001_0000, 0);
    chk("lhu_data", r_rdata,            32'h0000_8001);

    // Misaligned LH 0x201 and SW 0x101
    access(1'b0, 3'b001, 32'h0000_0201, 32'h0, 32'h0, 0);
    chk("mh_mis",   r_mis,              32'd1);
    chk("mh_req",   r_req,              32'd0);
    chk("mh_stall", r_stall,            32'd1);
    chk("mh_rdv",   r_rdv,              32'd0);
    chk("mh_post",  {31'd0, r_post},    32'd0);
    access(1'b1, 3'b010, 32'h0000_0101, 32'h1111_1111, 32'h0, 0);
    chk("mw_mis",   r_mis,              32'd1);
    chk("mw_req",   r_req,              32'd0);

    // LW with ack on fifth REQ cycle
    access(1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 4);
    chk("lw5_req",    r_req,            32'd5);
    chk("lw5_stable", {31'd0, r_stable}, 32'd1);
    chk("lw5_addr",   r_addr,           32'h0000_0104);
    chk("lw5_rdv",    r_rdv,            32'd1);
    chk("lw5_data",   r_rdata,          32'hCAFE_F00D);
    chk("lw5_stall",  r_stall,          32'd6);
    chk("lw5_err",    r_err,            32'd0);

    // Stray ack while idle is ignored
    bus.i_mem_ack = 1'b1; bus.i_mem_rdata = 32'h5555_5555;
    @(posedge clk); #1;
    chk("stray_rdv",  {31'd0, bus.o_rd_valid}, 32'd0);
    chk("stray_req",  {31'd0, bus.o_mem_req},  32'd0);
    chk("stray_data", bus.o_rd_wdata,          32'hCAFE_F00D);
    bus.i_mem_ack = 1'b0;

`ifdef LSU_TIMEOUT_EN
    // No ack: give up after 4 REQ cycles
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h0, -1);
    chk("tmo_req",   r_req,             32'd4);
    chk("tmo_err",   r_err,             32'd1);
    chk("tmo_rdv",   r_rdv,             32'd0);
    chk("tmo_stall", r_stall,           32'd5);
    chk("tmo_post",  {31'd0, r_post},   32'd0);
    // Ack in the limit cycle completes normally
    access(1'b0, 3'b010, 32'h0000_0300, 32'h0, 32'h1357_9BDF, 3);
    chk("lim_err",   r_err,             32'd0);
    chk("lim_rdv",   r_rdv,             32'd1);
    chk("lim_data",  r_rdata,           32'h1357_9BDF);
`else
    // No ack: request held indefinitely, never an error
    bus.i_valid = 1'b1; bus.i_store = 1'b0; bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h0000_0300; bus.i_mem_ack = 1'b0;
    @(posedge clk); #1;
    bus.i_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("hold_req",   {31'd0, bus.o_mem_req},  32'd1);
    chk("hold_err",   {31'd0, bus.o_bus_err},  32'd0);
    chk("hold_stall", {31'd0, bus.o_stall},    32'd1);
`endif

    // Reset in the middle of a request drops it without a clock edge
    bus.i_valid = 1'b1; bus.i_store = 1'b0; bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h0000_0400; bus.i_mem_ack = 1'b0;
    @(posedge clk); #1;
    chk("mid_req", {31'd0, bus.o_mem_req}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_req", {31'd0, bus.o_mem_req}, 32'd0);
    chk("async_addr", bus.o_mem_addr,        32'd0);
    bus.i_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("after_rst_req", {31'd0, bus.o_mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_lsu_seq

`default_nettype wire
